sram_ctrl: RTL

Parametrised single-clock controller for the off-chip asynchronous SRAM that holds processor program and data. It replaces hand-wired chip-enable, output-enable and write-enable glue with a sequenced interface:
- address setup, programmable wait states and data hold;
- a guaranteed bus turnaround gap between reads and writes;
- a valid/ready request port with a one-cycle read response.

It sits between the core's memory port and the board-level SRAM and tristate buffer.

---
 rtl/sram_ctrl_pkg.sv | 33 +++
 rtl/sram_wait_timer.sv | 34 +++
 rtl/sram_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and default timing for the asynchronous SRAM
// controller.
//   sram_state_t : controller sequencing states
//   sram_req_t   : request record (write flag, address, data) at default widths
//   DEF_*        : default widths and timing parameters
//   *_CNT_W      : widths of the access and turnaround counters
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_WAIT_RD = 1;
  localparam int DEF_WAIT_WR = 1;
  localparam int DEF_TURN    = 1;

  // Wait states span 0..15, turnaround spans 0..7.
  localparam int WAIT_CNT_W = 4;
  localparam int TURN_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_TURN
  } sram_state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sram_req_t;

endpackage

// File: rtl/sram_wait_timer.sv
// sram_wait_timer: loadable down-counter that stops at zero.
//   clk1    : clock, rising edge
//   reset   : synchronous, active low; clears the count
//   i_load  : load i_value this cycle (takes priority over counting)
//   i_value : load value
//   o_count : current count
//   o_done  : count is zero
module sram_wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_count,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequenced controller for an asynchronous SRAM.
//   clk1, reset            : clock (rising edge), synchronous active-low reset
//   req_valid/req_ready    : request handshake
//   req_write/addr/wdata   : request contents, registered at the handshake
//   rsp_valid/rsp_rdata    : one-cycle read response pulse and captured data
//   sram_ce_n/oe_n/we_n    : active-low SRAM strobes (registered)
//   sram_adr               : SRAM address
//   sram_dq_out/dq_oe      : write data and drive enable for the board tristate
//   sram_dq_in             : data returned from the SRAM
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WAIT_RD = DEF_WAIT_RD,
  parameter int WAIT_WR = DEF_WAIT_WR,
  parameter int TURN    = DEF_TURN
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  sram_state_t r_state, w_state_next;
  req_t        r_req;

  logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_ce_n_next, w_oe_n_next, w_we_n_next, w_dq_oe_next;

  logic                  w_hs, w_wr_next, w_rd_end, w_turn_owed;
  logic [WAIT_CNT_W-1:0] w_acc_value, w_acc_count;
  logic                  w_acc_done;
  logic [TURN_CNT_W-1:0] w_turn_count;
  logic                  w_turn_done;
  logic                  w_unused_acc_count;

  assign req_ready = (r_state == ST_IDLE) && reset;
  assign w_hs      = req_valid && req_ready;
  // Direction of the transfer the next cycle belongs to: the incoming
  // request at a handshake, otherwise the one already registered.
  assign w_wr_next = w_hs ? req_write : r_req.write;
  assign w_rd_end  = (r_state == ST_ACCESS) && w_acc_done && !r_req.write;

  // The counter includes the current cycle, so only a count above one
  // still owes idle cycles after this one.
  assign w_turn_owed = !w_turn_done && (w_turn_count != TURN_CNT_W'(1));

  assign w_acc_value = r_req.write ? WAIT_CNT_W'(WAIT_WR) : WAIT_CNT_W'(WAIT_RD);
  assign w_unused_acc_count = ^w_acc_count;

  // Loaded during SETUP so ACCESS sees W, W-1 .. 0: W+1 cycles.
  sram_wait_timer #(.WIDTH(WAIT_CNT_W)) u_access_timer (
    .clk1    (clk1),
    .reset   (reset),
    .i_load  (r_state == ST_SETUP),
    .i_value (w_acc_value),
    .o_count (w_acc_count),
    .o_done  (w_acc_done)
  );

  sram_wait_timer #(.WIDTH(TURN_CNT_W)) u_turn_timer (
    .clk1    (clk1),
    .reset   (reset),
    .i_load  (w_rd_end),
    .i_value (TURN_CNT_W'(TURN)),
    .o_count (w_turn_count),
    .o_done  (w_turn_done)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_hs) w_state_next = (req_write && w_turn_owed) ? ST_TURN : ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (w_acc_done) w_state_next = r_req.write ? ST_HOLD : ST_IDLE;
      ST_HOLD:   w_state_next = ST_IDLE;
      ST_TURN:   if (!w_turn_owed) w_state_next = ST_SETUP;
      default:   w_state_next = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave a flop
    // aligned with the state they belong to.
    w_ce_n_next  = 1'b1;
    w_oe_n_next  = 1'b1;
    w_we_n_next  = 1'b1;
    w_dq_oe_next = 1'b0;
    if (w_state_next == ST_SETUP || w_state_next == ST_ACCESS || w_state_next == ST_HOLD) begin
      w_ce_n_next  = 1'b0;
      w_dq_oe_next = w_wr_next;
    end
    if (w_state_next == ST_ACCESS) begin
      w_oe_n_next = w_wr_next;
      w_we_n_next = !w_wr_next;
    end
  end

  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ce_n      <= w_ce_n_next;
      r_oe_n      <= w_oe_n_next;
      r_we_n      <= w_we_n_next;
      r_dq_oe     <= w_dq_oe_next;
      r_rsp_valid <= w_rd_end;
      if (w_hs) begin
        r_req <= {req_write, req_addr, req_wdata};
      end
      if (w_rd_end) begin
        r_rsp_rdata <= sram_dq_in;
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_adr    = r_req.addr;
  assign sram_dq_out = r_req.data;

endmodule
